// File: rtl/instr_rom_loader.sv
// Boot-time program loader: assembles a little-endian byte stream into 32-bit
// words, writes them into the instruction ROM and holds the core in reset
// until the requested number of words has been written.
module instr_rom_loader #(
    parameter int unsigned MEM_SIZE  = 8*1024,
    parameter logic [31:0] MEM_START = 32'h0000_0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk_sys,
    input  logic             rst_sys,
    input  logic             start,
    input  logic [CNT_W-1:0] word_count,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             rom_we,
    output logic [3:0]       rom_be,
    output logic [31:0]      rom_addr,
    output logic [31:0]      rom_wdata,
    output logic             core_rst_n,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(MEM_SIZE / 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [31:0]      wbuf_q, wbuf_d;
    logic [31:0]      addr_q, addr_d;
    logic             err_q, err_d;

    logic             start_ok;
    logic [CNT_W-1:0] word_next;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            wbuf_q     <= '0;
            addr_q     <= MEM_START;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            wbuf_q     <= wbuf_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic: start validation, byte assembly, word sequencing
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        wbuf_d     = wbuf_q;
        addr_d     = addr_q;
        err_d      = err_q;

        start_ok  = (word_count != '0) && (word_count <= DEPTH);
        word_next = word_idx_q + CNT_W'(1);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (start_ok) begin
                        count_d    = word_count;
                        err_d      = 1'b0;
                        word_idx_d = '0;
                        byte_idx_d = '0;
                        wbuf_d     = '0;
                        state_d    = S_COLLECT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_COLLECT: begin
                if (in_valid) begin
                    case (byte_idx_q)
                        2'd0:    wbuf_d[7:0]   = in_data;
                        2'd1:    wbuf_d[15:8]  = in_data;
                        2'd2:    wbuf_d[23:16] = in_data;
                        default: wbuf_d[31:24] = in_data;
                    endcase
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Address is registered on entry to WRITE so it holds afterwards
                        addr_d  = MEM_START + 32'({word_idx_q, 2'b00});
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_next;
                state_d    = (word_next == count_q) ? S_DONE : S_COLLECT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state
    always_comb begin
        in_ready   = (state_q == S_COLLECT);
        busy       = (state_q == S_COLLECT) || (state_q == S_WRITE);
        done       = (state_q == S_DONE);
        core_rst_n = (state_q == S_DONE);
        rom_we     = (state_q == S_WRITE);
        rom_be     = (state_q == S_WRITE) ? 4'hF : 4'h0;
        rom_wdata  = (state_q == S_WRITE) ? wbuf_q : '0;
        rom_addr   = addr_q;
        err        = err_q;
    end

endmodule

// File: tb/tb_instr_rom_loader.sv
// Self-checking bench for instr_rom_loader: expected ROM writes are queued as
// bytes are scheduled and popped by a write monitor.
module tb_instr_rom_loader;

    logic        clk_sys = 1'b0;
    logic        rst_sys;
    logic        start;
    logic [15:0] word_count;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        rom_we;
    logic [3:0]  rom_be;
    logic [31:0] rom_addr;
    logic [31:0] rom_wdata;
    logic        core_rst_n;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk_sys = ~clk_sys;

    instr_rom_loader #(
        .MEM_SIZE (8*1024),
        .MEM_START(32'h0000_0000),
        .CNT_W    (16)
    ) dut (
        .clk_sys   (clk_sys),
        .rst_sys   (rst_sys),
        .start     (start),
        .word_count(word_count),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .rom_we    (rom_we),
        .rom_be    (rom_be),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .core_rst_n(core_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [7:0]  stream[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned we_count    = 0;
    int unsigned we_before;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Write monitor: every rom_we pulse must match the head of the scoreboard
    always @(negedge clk_sys) begin
        if (rom_we === 1'b1) begin
            we_count++;
            if (exp_q.size() == 0) begin
                chk("spurious_we", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", rom_addr, mon_e.addr);
                chk("wr_data", rom_wdata, mon_e.data);
                chk("wr_be", {28'd0, rom_be}, 32'hF);
                chk("rdy_in_write", {31'd0, in_ready}, 32'd0);
            end
        end else begin
            chk("idle_be", {28'd0, rom_be}, 32'd0);
            chk("idle_wdata", rom_wdata, 32'd0);
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_rom_we"}, {31'd0, rom_we}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_core_rst_n"}, {31'd0, core_rst_n}, 32'd0);
        chk({tag, "_rom_be"}, {28'd0, rom_be}, 32'd0);
        chk({tag, "_rom_addr"}, rom_addr, 32'h0);
        chk({tag, "_rom_wdata"}, rom_wdata, 32'd0);
    endtask

    // Called at a negedge; applies one reset edge, checks, releases
    task automatic do_reset(input string tag);
        rst_sys  = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk_sys);
        check_reset_vals(tag);
        rst_sys = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic pulse_start(input logic [15:0] cnt);
        start      = 1'b1;
        word_count = cnt;
        @(negedge clk_sys);
        start = 1'b0;
    endtask

    task automatic push_words(input int unsigned n);
        wr_t e;
        for (int unsigned w = 0; w < n; w++) begin
            e.addr = 32'(4 * w);
            e.data = {stream[4*w+3], stream[4*w+2], stream[4*w+1], stream[4*w]};
            exp_q.push_back(e);
        end
    endtask

    // Returns at the negedge after the last byte's accepting edge
    task automatic send_stream(input int unsigned duty_pct);
        int unsigned i = 0;
        int unsigned cycles = 0;
        while (i < stream.size() && cycles < 3000) begin
            in_valid = ($urandom_range(99) < duty_pct);
            in_data  = stream[i];
            if (in_valid && in_ready) i++;
            cycles++;
            @(negedge clk_sys);
        end
        in_valid = 1'b0;
        chk("stream_timeout", i, stream.size());
    endtask

    task automatic wait_done();
        int unsigned cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            @(negedge clk_sys);
            cycles++;
        end
        chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst_sys    = 1'b1;
        start      = 1'b0;
        word_count = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        @(negedge clk_sys);
        do_reset("rst0");

        // 1: single word
        stream.delete();
        stream.push_back(8'h13); stream.push_back(8'h00);
        stream.push_back(8'h00); stream.push_back(8'h00);
        push_words(1);
        we_before = we_count;
        pulse_start(16'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        send_stream(100);
        chk("t1_we", {31'd0, rom_we}, 32'd1);
        @(negedge clk_sys);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_core_rst_n", {31'd0, core_rst_n}, 32'd1);
        chk("t1_we_count", we_count - we_before, 32'd1);

        // 2: three words, back-to-back bytes
        stream.delete();
        for (int unsigned b = 0; b < 12; b++) stream.push_back(8'(b));
        push_words(3);
        we_before = we_count;
        pulse_start(16'd3);
        send_stream(100);
        wait_done();
        chk("t2_we_count", we_count - we_before, 32'd3);
        chk("t2_sb_empty", exp_q.size(), 32'd0);

        // 3: four words with sparse in_valid
        stream.delete();
        for (int unsigned b = 0; b < 16; b++) stream.push_back(8'(8'h20 + b));
        push_words(4);
        we_before = we_count;
        pulse_start(16'd4);
        send_stream(30);
        wait_done();
        chk("t3_we_count", we_count - we_before, 32'd4);
        chk("t3_sb_empty", exp_q.size(), 32'd0);

        // 4: rejected starts from IDLE
        do_reset("rst4");
        we_before = we_count;
        pulse_start(16'd0);
        chk("t4a_err", {31'd0, err}, 32'd1);
        chk("t4a_busy", {31'd0, busy}, 32'd0);
        chk("t4a_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        repeat (3) @(negedge clk_sys);
        chk("t4a_still_idle", {30'd0, busy, in_ready}, 32'd0);
        pulse_start(16'd2049);
        chk("t4b_err", {31'd0, err}, 32'd1);
        chk("t4b_busy", {31'd0, busy}, 32'd0);
        chk("t4b_done", {31'd0, done}, 32'd0);
        chk("t4b_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        chk("t4_no_we", we_count - we_before, 32'd0);

        // 5: reset in the middle of a two-word load
        stream.delete();
        for (int unsigned b = 0; b < 5; b++) stream.push_back(8'(8'hA0 + b));
        push_words(1);
        pulse_start(16'd2);
        chk("t5_err_cleared", {31'd0, err}, 32'd0);
        send_stream(100);
        do_reset("t5_midrst");
        stream.delete();
        stream.push_back(8'hEF); stream.push_back(8'hBE);
        stream.push_back(8'hAD); stream.push_back(8'hDE);
        push_words(1);
        we_before = we_count;
        pulse_start(16'd1);
        send_stream(100);
        wait_done();
        chk("t5_we_count", we_count - we_before, 32'd1);

        // 6: reload from DONE; starts while busy are ignored
        stream.delete();
        stream.push_back(8'h11); stream.push_back(8'h22);
        stream.push_back(8'h33); stream.push_back(8'h44);
        push_words(1);
        we_before = we_count;
        pulse_start(16'd1);
        chk("t6_core_rst_n_fall", {31'd0, core_rst_n}, 32'd0);
        chk("t6_done_fall", {31'd0, done}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd1);
        pulse_start(16'd0);
        chk("t6_busy_start_err", {31'd0, err}, 32'd0);
        chk("t6_busy_start_busy", {31'd0, busy}, 32'd1);
        pulse_start(16'd5);
        send_stream(100);
        wait_done();
        chk("t6_core_rst_n", {31'd0, core_rst_n}, 32'd1);
        chk("t6_we_count", we_count - we_before, 32'd1);
        pulse_start(16'd0);
        chk("t6_done_bad_err", {31'd0, err}, 32'd1);
        chk("t6_done_bad_done", {31'd0, done}, 32'd1);
        chk("t6_done_bad_rst_n", {31'd0, core_rst_n}, 32'd1);
        pulse_start(16'd2048);
        chk("t6_depth_err", {31'd0, err}, 32'd0);
        chk("t6_depth_busy", {31'd0, busy}, 32'd1);
        do_reset("rst_end");
        chk("end_sb_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
